// File: rtl/cache_tag_array.sv
// Set-associative cache tag array: per-set/way tag, valid and dirty state,
// per-set round-robin replacement pointer, registered lookup results with
// victim selection, and a one-set-per-cycle invalidate-all flush walk.
module cache_tag_array #(
    parameter int WAYS      = 2,
    parameter int SET_WIDTH = 7,
    parameter int TAG_WIDTH = 21,
    localparam int WW       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [SET_WIDTH-1:0] req_index,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic [WW-1:0]        req_way,
    input  logic                 req_dirty,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [WW-1:0]        resp_way,
    output logic                 resp_dirty,
    output logic [WW-1:0]        victim_way,
    output logic                 victim_valid,
    output logic                 victim_dirty,
    output logic [TAG_WIDTH-1:0] victim_tag,
    input  logic                 flush_req,
    output logic                 flush_busy
);

    localparam int SETS = 1 << SET_WIDTH;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_DIRTY  = 2'b10;
    localparam logic [1:0] OP_INVAL  = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WALK = 1'b1;

    // Array state
    logic [TAG_WIDTH-1:0] r_tag   [SETS][WAYS];
    logic [WAYS-1:0]      r_valid [SETS];
    logic [WAYS-1:0]      r_dirty [SETS];
    logic [WW-1:0]        r_ptr   [SETS];

    // Flush walk state
    logic [0:0]           r_state;
    logic [SET_WIDTH-1:0] r_flush_cnt;

    // Registered lookup results
    logic                 r_resp_valid;
    logic                 r_resp_hit;
    logic [WW-1:0]        r_resp_way;
    logic                 r_resp_dirty;
    logic [WW-1:0]        r_victim_way;
    logic                 r_victim_valid;
    logic                 r_victim_dirty;
    logic [TAG_WIDTH-1:0] r_victim_tag;

    logic                 w_flush_busy;
    logic                 w_accept;
    logic [WW-1:0]        w_way;
    logic [WW-1:0]        w_next_ptr;
    logic                 w_hit;
    logic [WW-1:0]        w_hit_way;
    logic                 w_hit_dirty;
    logic                 w_inv_found;
    logic [WW-1:0]        w_inv_way;
    logic [WW-1:0]        w_vic_way;

    assign w_flush_busy = (r_state == ST_WALK);
    assign flush_busy   = w_flush_busy;
    // A flush request in the same cycle as a request blocks the request.
    assign req_ready    = !w_flush_busy && !flush_req;
    assign w_accept     = req_valid && req_ready;

    // With a single way every way field collapses to constant 0.
    assign w_way      = (WAYS == 1) ? '0 : req_way;
    assign w_next_ptr = (WAYS == 1) ? '0 : req_way + WW'(1);

    // Hit search (lowest hitting way) and victim choice against current contents.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_hit_dirty = 1'b0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && r_valid[req_index][w] && (r_tag[req_index][w] == req_tag)) begin
                w_hit       = 1'b1;
                w_hit_way   = WW'(w);
                w_hit_dirty = r_dirty[req_index][w];
            end
            if (!w_inv_found && !r_valid[req_index][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WW'(w);
            end
        end
        w_vic_way = w_inv_found ? w_inv_way : r_ptr[req_index];
    end

    // Flush FSM: IDLE waits for flush_req, WALK steps the set counter once per cycle.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (flush_req) begin
                        r_state     <= ST_WALK;
                        r_flush_cnt <= '0;
                    end
                end
                ST_WALK: begin
                    r_flush_cnt <= r_flush_cnt + SET_WIDTH'(1);
                    if (&r_flush_cnt) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Valid/dirty/pointer updates from accepted ops and from the flush walk.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only the small valid/dirty/pointer flops take the async reset;
            // the tag storage is left unreset so it can map onto plain memory,
            // and a cleared valid bit already makes any stale tag harmless.
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else if (w_flush_busy) begin
            r_valid[r_flush_cnt] <= '0;
            r_dirty[r_flush_cnt] <= '0;
            r_ptr[r_flush_cnt]   <= '0;
        end else if (w_accept) begin
            case (req_op)
                OP_FILL: begin
                    r_valid[req_index][w_way] <= 1'b1;
                    r_dirty[req_index][w_way] <= req_dirty;
                    r_ptr[req_index]          <= w_next_ptr;
                end
                OP_DIRTY: begin
                    if (r_valid[req_index][w_way]) begin
                        r_dirty[req_index][w_way] <= 1'b1;
                    end
                end
                OP_INVAL: begin
                    r_valid[req_index][w_way] <= 1'b0;
                    r_dirty[req_index][w_way] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag storage write on fill.
    always_ff @(posedge CLK) begin
        if (w_accept && (req_op == OP_FILL)) begin
            r_tag[req_index][w_way] <= req_tag;
        end
    end

    // Register lookup results; resp_valid pulses for one cycle per accepted lookup.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid   <= 1'b0;
            r_resp_hit     <= 1'b0;
            r_resp_way     <= '0;
            r_resp_dirty   <= 1'b0;
            r_victim_way   <= '0;
            r_victim_valid <= 1'b0;
            r_victim_dirty <= 1'b0;
            r_victim_tag   <= '0;
        end else begin
            r_resp_valid <= w_accept && (req_op == OP_LOOKUP);
            if (w_accept && (req_op == OP_LOOKUP)) begin
                r_resp_hit     <= w_hit;
                r_resp_way     <= w_hit_way;
                r_resp_dirty   <= w_hit_dirty;
                r_victim_way   <= w_vic_way;
                r_victim_valid <= !w_inv_found;
                r_victim_dirty <= r_dirty[req_index][w_vic_way];
                r_victim_tag   <= r_tag[req_index][w_vic_way];
            end
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_hit     = r_resp_hit;
    assign resp_way     = r_resp_way;
    assign resp_dirty   = r_resp_dirty;
    assign victim_way   = r_victim_way;
    assign victim_valid = r_victim_valid;
    assign victim_dirty = r_victim_dirty;
    assign victim_tag   = r_victim_tag;

endmodule

// File: tb/tb_cache_tag_array.sv
// Self-checking bench for cache_tag_array: directed scenarios plus random
// op traffic compared against a behavioural line/pointer model.
module tb_cache_tag_array;

    localparam int WAYS = 2;
    localparam int SW   = 7;
    localparam int TW   = 21;
    localparam int WW   = 1;
    localparam int SETS = 128;

    localparam logic [1:0] LOOKUP = 2'b00;
    localparam logic [1:0] FILL   = 2'b01;
    localparam logic [1:0] DIRTY  = 2'b10;
    localparam logic [1:0] INVAL  = 2'b11;

    logic          CLK;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [SW-1:0] req_index;
    logic [TW-1:0] req_tag;
    logic [WW-1:0] req_way;
    logic          req_dirty;
    logic          resp_valid;
    logic          resp_hit;
    logic [WW-1:0] resp_way;
    logic          resp_dirty;
    logic [WW-1:0] victim_way;
    logic          victim_valid;
    logic          victim_dirty;
    logic [TW-1:0] victim_tag;
    logic          flush_req;
    logic          flush_busy;

    cache_tag_array #(.WAYS(WAYS), .SET_WIDTH(SW), .TAG_WIDTH(TW)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_index(req_index), .req_tag(req_tag), .req_way(req_way),
        .req_dirty(req_dirty),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_dirty(resp_dirty),
        .victim_way(victim_way), .victim_valid(victim_valid),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .flush_req(flush_req), .flush_busy(flush_busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural model: what each cache line holds, and the next way to replace.
    typedef struct {
        bit          v;
        bit          d;
        bit [TW-1:0] t;
    } line_t;

    line_t m_line [SETS][WAYS];
    int    m_ptr  [SETS];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_line[s][w].v = 1'b0;
                m_line[s][w].d = 1'b0;
            end
        end
    endtask

    // Drive one request for one cycle; returns #1 after the accept edge.
    task automatic drive(input logic [1:0] op, input int idx, input logic [TW-1:0] tag,
                         input int way, input bit dirty);
        req_valid = 1'b1;
        req_op    = op;
        req_index = SW'(idx);
        req_tag   = tag;
        req_way   = WW'(way);
        req_dirty = dirty;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input int idx,
                         input logic [TW-1:0] tag, input int way, input bit dirty);
        drive(op, idx, tag, way, dirty);
        case (op)
            FILL: begin
                m_line[idx][way].v = 1'b1;
                m_line[idx][way].d = dirty;
                m_line[idx][way].t = tag;
                m_ptr[idx] = (way + 1) % WAYS;
            end
            DIRTY: if (m_line[idx][way].v) m_line[idx][way].d = 1'b1;
            INVAL: begin
                m_line[idx][way].v = 1'b0;
                m_line[idx][way].d = 1'b0;
            end
            default: ;
        endcase
        check({name, "/no_resp"}, 64'(resp_valid), 64'(0));
    endtask

    task automatic do_lookup(input string name, input int idx, input logic [TW-1:0] tag);
        bit e_hit = 0;
        int e_way = 0;
        bit e_dirty = 0;
        int e_vway = -1;
        bit e_vvalid;
        for (int w = 0; w < WAYS; w++) begin
            if (!e_hit && m_line[idx][w].v && m_line[idx][w].t == tag) begin
                e_hit = 1;
                e_way = w;
                e_dirty = m_line[idx][w].d;
            end
            if (e_vway < 0 && !m_line[idx][w].v) e_vway = w;
        end
        e_vvalid = (e_vway < 0);
        if (e_vvalid) e_vway = m_ptr[idx];
        drive(LOOKUP, idx, tag, 0, 0);
        check({name, "/resp_valid"},   64'(resp_valid),   64'(1));
        check({name, "/resp_hit"},     64'(resp_hit),     64'(e_hit));
        check({name, "/resp_way"},     64'(resp_way),     64'(e_way));
        check({name, "/resp_dirty"},   64'(resp_dirty),   64'(e_dirty));
        check({name, "/victim_way"},   64'(victim_way),   64'(e_vway));
        check({name, "/victim_valid"}, 64'(victim_valid), 64'(e_vvalid));
        if (e_vvalid) begin
            check({name, "/victim_dirty"}, 64'(victim_dirty), 64'(m_line[idx][e_vway].d));
            check({name, "/victim_tag"},   64'(victim_tag),   64'(m_line[idx][e_vway].t));
        end
    endtask

    // Pulse flush_req for one cycle and follow the walk; returns #1 after it ends.
    task automatic run_flush(input string name);
        int  busy_cycles = 0;
        bit  ready_seen = 0;
        bit  resp_seen = 0;
        flush_req = 1'b1;
        @(posedge CLK);
        #1;
        flush_req = 1'b0;
        // Keep a lookup pending throughout; it must not be accepted.
        req_valid = 1'b1;
        req_op    = LOOKUP;
        req_index = '0;
        while (flush_busy && busy_cycles < 300) begin
            busy_cycles++;
            if (req_ready) ready_seen = 1;
            if (resp_valid) resp_seen = 1;
            @(posedge CLK);
            #1;
        end
        req_valid = 1'b0;
        model_clear();
        check({name, "/busy_cycles"}, 64'(busy_cycles), 64'(SETS));
        check({name, "/ready_low"},   64'(ready_seen),  64'(0));
        check({name, "/no_resp"},     64'(resp_seen),   64'(0));
        check({name, "/ready_after"}, 64'(req_ready),   64'(1));
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_index = '0;
        req_tag = '0;
        req_way = '0;
        req_dirty = 1'b0;
        flush_req = 1'b0;
        model_clear();

        // Reset state
        #12;
        check("rst/resp_valid",   64'(resp_valid),   64'(0));
        check("rst/resp_hit",     64'(resp_hit),     64'(0));
        check("rst/victim_valid", 64'(victim_valid), 64'(0));
        check("rst/victim_way",   64'(victim_way),   64'(0));
        check("rst/flush_busy",   64'(flush_busy),   64'(0));
        check("rst/req_ready",    64'(req_ready),    64'(1));
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;

        // First lookup after reset misses, victim is invalid way 0
        do_lookup("look5_empty", 5, 21'h1234);
        check("look5_empty/vway0", 64'(victim_way), 64'(0));

        // Fill then hit; the response pulse drops after one cycle
        do_op("fill5", FILL, 5, 21'h1234, 1, 0);
        do_lookup("look5_hit", 5, 21'h1234);
        check("look5_hit/way1", 64'(resp_way), 64'(1));
        @(posedge CLK);
        #1;
        check("pulse_one_cycle", 64'(resp_valid), 64'(0));

        // Full set, dirty victim selected by the round-robin pointer
        do_op("fill9a", FILL, 9, 21'h0AAAA, 0, 0);
        do_op("fill9b", FILL, 9, 21'h0BBBB, 1, 0);
        do_op("dirty9", DIRTY, 9, 21'h0, 0, 0);
        do_lookup("look9_miss", 9, 21'h0CCCC);
        check("look9_miss/vtagA", 64'(victim_tag), 64'(21'h0AAAA));

        // Set-dirty on an invalid way, invalidate, duplicate tags (lowest way wins)
        do_op("dirty_inv", DIRTY, 20, 21'h0, 1, 0);
        do_lookup("look20", 20, 21'h0);
        do_op("fill20a", FILL, 20, 21'h777, 1, 1);
        do_op("fill20b", FILL, 20, 21'h777, 0, 0);
        do_lookup("look20_dup", 20, 21'h777);
        do_op("inval20", INVAL, 20, 21'h0, 0, 0);
        do_lookup("look20_inv", 20, 21'h777);

        // Random traffic over a few sets with a small tag pool
        for (int i = 0; i < 400; i++) begin
            int idx;
            int sel;
            logic [1:0]    op;
            logic [TW-1:0] tag;
            sel = int'($urandom_range(0, 3));
            idx = (sel == 0) ? 3 : (sel == 1) ? 5 : (sel == 2) ? 64 : 127;
            tag = TW'(21'h100 + $urandom_range(0, 4));
            op  = 2'($urandom_range(0, 3));
            if (op == LOOKUP) do_lookup("rand_look", idx, tag);
            else do_op("rand_op", op, idx, tag, int'($urandom_range(0, WAYS - 1)),
                       bit'($urandom_range(0, 1)));
        end

        // Flush after filling sets 0, 64, 127; a lookup in flight still responds
        do_op("fill0",   FILL, 0,   21'h1, 0, 1);
        do_op("fill64",  FILL, 64,  21'h2, 1, 0);
        do_op("fill127", FILL, 127, 21'h3, 0, 0);
        req_valid = 1'b1;
        req_op    = LOOKUP;
        req_index = SW'(64);
        req_tag   = 21'h2;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        flush_req = 1'b1;
        check("inflight/resp_valid", 64'(resp_valid), 64'(1));
        check("inflight/resp_hit",   64'(resp_hit),   64'(1));
        flush_req = 1'b0;
        run_flush("flush1");
        do_lookup("post_flush0",   0,   21'h1);
        do_lookup("post_flush64",  64,  21'h2);
        do_lookup("post_flush127", 127, 21'h3);
        do_lookup("post_flush5",   5,   21'h1234);

        // flush_req and lookup in the same cycle: flush wins
        do_op("fill33", FILL, 33, 21'h55, 1, 0);
        flush_req = 1'b1;
        req_valid = 1'b1;
        req_op    = LOOKUP;
        req_index = SW'(33);
        req_tag   = 21'h55;
        #1;
        check("collide/ready_low", 64'(req_ready), 64'(0));
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        flush_req = 1'b0;
        check("collide/no_resp", 64'(resp_valid), 64'(0));
        check("collide/busy",    64'(flush_busy), 64'(1));
        cyc = 0;
        while (flush_busy && cyc < 300) begin
            cyc++;
            @(posedge CLK);
            #1;
        end
        model_clear();
        check("collide/walk_len", 64'(cyc), 64'(SETS));
        do_lookup("collide/look33", 33, 21'h55);

        // Reset in the middle of a flush walk
        do_op("fill7",  FILL, 7,   21'h99, 0, 1);
        do_op("fill100", FILL, 100, 21'h98, 1, 1);
        flush_req = 1'b1;
        @(posedge CLK);
        #1;
        flush_req = 1'b0;
        repeat (40) @(posedge CLK);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst/busy_low", 64'(flush_busy), 64'(0));
        check("midrst/resp_low", 64'(resp_valid), 64'(0));
        model_clear();
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst/ready", 64'(req_ready), 64'(1));
        do_lookup("midrst/look7",   7,   21'h99);
        do_lookup("midrst/look100", 100, 21'h98);
        begin
            int hits = 0;
            for (int s = 0; s < SETS; s++) begin
                drive(LOOKUP, s, 21'h99, 0, 0);
                if (resp_hit || victim_valid) hits++;
            end
            check("midrst/all_invalid", 64'(hits), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
